// File: rtl/conv_tile_feeder.sv
// Tile feeder for conv_rapida: buffers a streamed map in five circular row slots and issues 5x5 stride-3 tiles.
// Optional zero padding (top/left plus right/bottom fill) is enabled with `define CONV_TILE_FEEDER_PAD_EN.
package packConv;
    localparam int ELEM_W = 16;
    typedef logic [24:0][ELEM_W-1:0] param25;
endpackage

module conv_tile_feeder #(
    parameter int QUANT = 8,
    parameter int IMG_W = 14,
    parameter int IMG_H = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [QUANT-1:0]         pixel_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output packConv::param25         tile,
    output logic                     start,
    input  logic                     conv_done,
    output logic [$clog2(IMG_H)-1:0] tile_row,
    output logic [$clog2(IMG_W)-1:0] tile_col,
    output logic                     frame_done,
    output logic                     busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int EW = packConv::ELEM_W;
`ifdef CONV_TILE_FEEDER_PAD_EN
    localparam int OFF = 1;
    localparam int TX  = (IMG_W + 2) / 3;
    localparam int TY  = (IMG_H + 2) / 3;
`else
    localparam int OFF = 0;
    localparam int TX  = (IMG_W - 2) / 3;
    localparam int TY  = (IMG_H - 2) / 3;
    generate
        if ((IMG_W - 2) % 3 != 0 || (IMG_H - 2) % 3 != 0) begin : g_geom_check
            $error("conv_tile_feeder: IMG_W-2 and IMG_H-2 must be multiples of 3");
        end
    endgenerate
`endif

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       row, row_nxt;      // slot row relative to base being filled
    logic [CW-1:0]    col, col_nxt;
    logic [CW-1:0]    tx, tx_nxt;
    logic [RW-1:0]    ty, ty_nxt;
    logic [2:0]       base, base_nxt;
    logic [2:0]       wr_slot, rd_slot;
    logic             wr_en;
    logic [QUANT-1:0] wr_data;
    logic             zero_row;
    int               cidx;
    packConv::param25 tile_nxt;
    logic [QUANT-1:0] mem [5][IMG_W];

    function automatic logic [2:0] mod5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    assign wr_slot = mod5({1'b0, base} + {1'b0, row});
    assign busy    = (state != IDLE);

`ifdef CONV_TILE_FEEDER_PAD_EN
    int src_row;
    assign src_row  = 3 * int'(ty) - 1 + int'(row);
    assign zero_row = (src_row < 0) || (src_row >= IMG_H);
`else
    assign zero_row = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        tx_nxt     = tx;
        ty_nxt     = ty;
        base_nxt   = base;
        wr_en      = 1'b0;
        wr_data    = '0;
        in_ready   = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                state_nxt = FILL;
                row_nxt   = '0;
                col_nxt   = '0;
                tx_nxt    = '0;
                ty_nxt    = '0;
                base_nxt  = '0;
            end
            FILL: begin
                // padding rows are synthesized in place without consuming input
                in_ready = !zero_row;
                wr_en    = zero_row || in_valid;
                wr_data  = zero_row ? '0 : pixel_in;
                if (wr_en) begin
                    if (col == CW'(IMG_W - 1)) begin
                        col_nxt = '0;
                        if (row == 3'd4) state_nxt = ISSUE;
                        else             row_nxt   = row + 3'd1;
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (conv_done) begin
                if (tx < CW'(TX - 1)) begin
                    tx_nxt    = tx + 1'b1;
                    state_nxt = ISSUE;
                end else if (ty < RW'(TY - 1)) begin
                    // bottom two rows of this band become the top of the next
                    tx_nxt    = '0;
                    ty_nxt    = ty + 1'b1;
                    base_nxt  = mod5({1'b0, base} + 4'd3);
                    row_nxt   = 3'd2;
                    col_nxt   = '0;
                    state_nxt = FILL;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gather the next tile; the pixel written this cycle is forwarded so the tile can issue right after it.
    always_comb begin
        tile_nxt = '0;
        rd_slot  = '0;
        cidx     = 0;
        for (int r = 0; r < 5; r++) begin
            rd_slot = mod5({1'b0, base} + 4'(r));
            for (int c = 0; c < 5; c++) begin
                cidx = 3 * int'(tx_nxt) - OFF + c;
`ifdef CONV_TILE_FEEDER_PAD_EN
                if (cidx >= 0 && cidx < IMG_W) begin
`else
                begin
`endif
                    if (wr_en && wr_slot == rd_slot && int'(col) == cidx)
                        tile_nxt[r*5+c] = EW'(wr_data);
                    else
                        tile_nxt[r*5+c] = EW'(mem[rd_slot][CW'(cidx)]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_slot][col] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            tx       <= '0;
            ty       <= '0;
            base     <= '0;
            tile     <= '0;
            tile_row <= '0;
            tile_col <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            tx    <= tx_nxt;
            ty    <= ty_nxt;
            base  <= base_nxt;
            if (state_nxt == ISSUE) begin
                tile     <= tile_nxt;
                tile_row <= ty_nxt;
                tile_col <= tx_nxt;
            end
        end
    end
endmodule

// File: tb/tb_conv_tile_feeder.sv
// Scoreboard bench for conv_tile_feeder: reference tiles come from image coordinates, a 10-cycle core model answers start.
module tb_conv_tile_feeder;
    localparam int QUANT = 8;
    localparam int W = 14;
    localparam int H = 14;
    localparam int EW = packConv::ELEM_W;
`ifdef CONV_TILE_FEEDER_PAD_EN
    localparam int OFF = 1;
    localparam int TX = (W + 2) / 3;
    localparam int TY = (H + 2) / 3;
`else
    localparam int OFF = 0;
    localparam int TX = (W - 2) / 3;
    localparam int TY = (H - 2) / 3;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [QUANT-1:0] pixel_in = '0;
    logic in_valid = 1'b0;
    logic in_ready, start, conv_done, frame_done, busy;
    packConv::param25 tile;
    logic [$clog2(H)-1:0] tile_row;
    logic [$clog2(W)-1:0] tile_col;

    typedef struct {
        int row;
        int col;
        packConv::param25 t;
    } exp_t;

    exp_t q[$];
    packConv::param25 got [64];
    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int core_cd = 0;
    int core_hold = 0;
    int hold_len = 1;
    bit spur_en = 0;
    bit force_done = 0;
    bit abort = 0;

    conv_tile_feeder #(.QUANT(QUANT), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid),
        .in_ready(in_ready), .tile(tile), .start(start), .conv_done(conv_done),
        .tile_row(tile_row), .tile_col(tile_col), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // core model: data_valid 10 cycles after start, optionally held; plus injected spurious pulses
    assign conv_done = (core_hold > 0) || force_done;
    always @(negedge clk) if (start === 1'b1) core_cd = 10;
    always @(posedge clk) begin
        #1;
        if (core_hold > 0) core_hold--;
        if (core_cd > 0) begin
            core_cd--;
            if (core_cd == 0) core_hold = hold_len;
        end
        force_done = spur_en && (in_ready === 1'b1 || start === 1'b1);
    end

    function automatic logic [QUANT-1:0] pix(input int r, input int c);
        return QUANT'(r * 16 + c);
    endfunction

    function automatic logic [EW-1:0] ref_el(input int ty, input int tx, input int r, input int c);
        int rr, cc;
        rr = 3 * ty - OFF + r;
        cc = 3 * tx - OFF + c;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) return '0;
        return EW'(pix(rr, cc));
    endfunction

    task automatic run_frame(input bit thr, input int hl, input bit spur, input string tag);
        exp_t e;
        int idx, cyc_d, cyc_m, nstart, nfd, exp_acc, rows;
        hold_len = hl;
        spur_en = spur;
        acc_cnt = 0;
        nstart = 0;
        nfd = 0;
        q.delete();
        for (int ty = 0; ty < TY; ty++)
            for (int tx = 0; tx < TX; tx++) begin
                e.row = ty;
                e.col = tx;
                for (int k = 0; k < 25; k++) e.t[k] = ref_el(ty, tx, k / 5, k % 5);
                q.push_back(e);
            end
        @(posedge clk); #1;
        fork
            begin
                idx = 0;
                cyc_d = 0;
                while (idx < W * H && cyc_d < 6000 && !abort) begin
                    cyc_d++;
                    if (thr && $urandom_range(0, 2) == 0) in_valid = 1'b0;
                    else begin
                        in_valid = 1'b1;
                        pixel_in = pix(idx / W, idx % W);
                    end
                    @(negedge clk);
                    if (in_valid && in_ready === 1'b1) begin
                        idx++;
                        acc_cnt++;
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                cyc_m = 0;
                while (nfd == 0 && cyc_m < 6000) begin
                    @(negedge clk);
                    cyc_m++;
                    if (start === 1'b1) begin
                        nstart++;
                        total++;
                        if (q.size() == 0) begin
                            bad++;
                            $display("FAIL %s extra_start row=%0d col=%0d", tag, tile_row, tile_col);
                        end else begin
                            e = q.pop_front();
                            if (int'(tile_row) !== e.row || int'(tile_col) !== e.col) begin
                                bad++;
                                $display("FAIL %s tile_index got=(%0d,%0d) want=(%0d,%0d)", tag, tile_row, tile_col, e.row, e.col);
                            end
                            total++;
                            if (tile !== e.t) begin
                                bad++;
                                $display("FAIL %s tile_data (%0d,%0d) got=%h want=%h", tag, e.row, e.col, tile, e.t);
                            end
                            if (e.row * TX + e.col < 64) got[e.row * TX + e.col] = tile;
                            if (e.col == 0) begin
                                rows = 5 - OFF + 3 * e.row;
                                if (rows > H) rows = H;
                                exp_acc = rows * W;
                                total++;
                                if (acc_cnt !== exp_acc) begin
                                    bad++;
                                    $display("FAIL %s accepted_before_band%0d got=%0d want=%0d", tag, e.row, acc_cnt, exp_acc);
                                end
                            end
                        end
                    end
                    if (frame_done === 1'b1) nfd++;
                end
            end
        join
        spur_en = 0;
        hold_len = 1;
        total++;
        if (nfd != 1) begin
            bad++;
            $display("FAIL %s frame_done_timeout got=%0d want=1", tag, nfd);
        end
        total++;
        if (nstart !== TX * TY) begin
            bad++;
            $display("FAIL %s start_count got=%0d want=%0d", tag, nstart, TX * TY);
        end
        total++;
        if (acc_cnt !== W * H) begin
            bad++;
            $display("FAIL %s pixels_accepted got=%0d want=%0d", tag, acc_cnt, W * H);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || start !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after_frame busy=%b start=%b frame_done=%b want 0 0 0", tag, busy, start, frame_done);
        end
        q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || start !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl in_ready=%b start=%b frame_done=%b busy=%b want 0", in_ready, start, frame_done, busy);
        end
        total++;
        if (tile !== '0 || tile_row !== '0 || tile_col !== '0) begin
            bad++;
            $display("FAIL reset_data tile=%h row=%0d col=%0d want 0", tile, tile_row, tile_col);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(0, 1, 0, "full_frame");
    endtask

    task automatic test_tile_contents();
        packConv::param25 t;
        run_frame(0, 1, 0, "contents");
`ifdef CONV_TILE_FEEDER_PAD_EN
        t = got[0];
        total++;
        if (t[0] !== '0 || t[1] !== '0 || t[2] !== '0 || t[3] !== '0 || t[4] !== '0 || t[5] !== '0 || t[10] !== '0) begin
            bad++;
            $display("FAIL pad_tile00_border got=%h want zeros in 0..5,10", t);
        end
        total++;
        if (t[6] !== 16'h0000 || t[24] !== 16'h0033) begin
            bad++;
            $display("FAIL pad_tile00_data e6=%h e24=%h want 0000 0033", t[6], t[24]);
        end
        t = got[4 * TX + 4];
        total++;
        if (t[0] !== 16'h00BB) begin
            bad++;
            $display("FAIL pad_tile44_e0 got=%h want 00bb", t[0]);
        end
        for (int k = 0; k < 25; k++)
            if (k / 5 >= 3 || k % 5 >= 3) begin
                total++;
                if (t[k] !== '0) begin
                    bad++;
                    $display("FAIL pad_tile44_oob e%0d got=%h want 0", k, t[k]);
                end
            end
`else
        t = got[0];
        total++;
        if (t[0] !== 16'h0000 || t[24] !== 16'h0044) begin
            bad++;
            $display("FAIL tile00 e0=%h e24=%h want 0000 0044", t[0], t[24]);
        end
        t = got[1 * TX + 2];
        total++;
        if (t[0] !== 16'h0036 || t[24] !== 16'h007A) begin
            bad++;
            $display("FAIL tile12 e0=%h e24=%h want 0036 007a", t[0], t[24]);
        end
`endif
    endtask

    task automatic test_backpressure();
        run_frame(1, 1, 0, "backpressure");
    endtask

    task automatic test_spurious_conv_done();
        run_frame(0, 1, 1, "spurious_done");
    endtask

    task automatic test_held_conv_done();
        run_frame(0, 3, 0, "held_done");
    endtask

    task automatic test_reset_mid_frame();
        int cyc, idx;
        bit hit;
        hit = 0;
        abort = 0;
        @(posedge clk); #1;
        fork
            begin
                idx = 0;
                while (idx < W * H && !abort) begin
                    in_valid = 1'b1;
                    pixel_in = pix(idx / W, idx % W);
                    @(negedge clk);
                    if (in_ready === 1'b1) idx++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (!hit && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    if (start === 1'b1 && tile_row == 2) hit = 1;
                end
                abort = 1;
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
            end
        join
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL reset_mid band2_not_reached got=0 want=1");
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || start !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 ||
            tile !== '0 || tile_row !== '0 || tile_col !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs busy=%b in_ready=%b start=%b row=%0d col=%0d tile=%h want all 0",
                     busy, in_ready, start, tile_row, tile_col, tile);
        end
        abort = 0;
        repeat (15) @(posedge clk);
        run_frame(0, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_tile_contents();
        test_backpressure();
        test_spurious_conv_done();
        test_held_conv_done();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
